// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types.
//   aluop_t        : operation select for the combinational ALU
//   muldiv_op_t    : operation select for the multiply/divide sequencer
//   muldiv_state_t : sequencer FSM states
//   MULDIV_ITER    : number of shift/add or shift/subtract iterations
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } aluop_t;

    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_DIVU  = 1'b1
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        DIV_CMP = 3'd2,
        DIV_SUB = 3'd3,
        DONE    = 3'd4
    } muldiv_state_t;

    localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Combinational ALU shared by the datapath and the multiply/divide sequencer.
// Ports:
//   alu_port_A, alu_port_B : operands
//   alu_aluop              : operation select (aluop_t)
//   alu_output_port        : result (SLT/SLTU return 0 or 1 in bit 0)
//   alu_overflow           : ADD -> unsigned carry-out, SUB -> borrow-out,
//                            0 for every other operation
// ---------------------------------------------------------------------------
module cpu_alu
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] alu_port_A,
    input  logic [WIDTH-1:0] alu_port_B,
    input  aluop_t           alu_aluop,
    output logic [WIDTH-1:0] alu_output_port,
    output logic             alu_overflow
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, alu_port_A} + {1'b0, alu_port_B};
    assign diff_ext = {1'b0, alu_port_A} - {1'b0, alu_port_B};

    always_comb begin
        alu_output_port = '0;
        alu_overflow    = 1'b0;
        case (alu_aluop)
            ALU_ADD: begin
                alu_output_port = sum_ext[WIDTH-1:0];
                alu_overflow    = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                alu_output_port = diff_ext[WIDTH-1:0];
                alu_overflow    = diff_ext[WIDTH];
            end
            ALU_AND:  alu_output_port = alu_port_A & alu_port_B;
            ALU_OR:   alu_output_port = alu_port_A | alu_port_B;
            ALU_XOR:  alu_output_port = alu_port_A ^ alu_port_B;
            ALU_NOR:  alu_output_port = ~(alu_port_A | alu_port_B);
            ALU_SLT:  alu_output_port = {{(WIDTH-1){1'b0}},
                                         ($signed(alu_port_A) < $signed(alu_port_B))};
            ALU_SLTU: alu_output_port = {{(WIDTH-1){1'b0}}, (alu_port_A < alu_port_B)};
            default:  alu_output_port = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle unsigned MULTU / DIVU sequencer producing HI/LO. Every add,
// subtract and compare is delegated to an external combinational ALU; the
// sequencer only shifts and steers operands.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   start, op         : request (sampled only in IDLE) and operation
//   opa, opb          : multiplicand/dividend, multiplier/divisor
//   busy, done        : busy outside IDLE, one-cycle done pulse in DONE
//   hi, lo            : product {hi,lo}, or remainder (hi) / quotient (lo)
//   alu_port_A/B      : ALU operands driven by the sequencer
//   alu_aluop         : ALU operation driven by the sequencer
//   alu_output_port   : ALU result, consumed in the same cycle
//   alu_overflow      : ALU carry-out, used as the product carry-in
// Latency from the accepting edge: 32 MUL cycles or 32 CMP/SUB pairs,
// followed by one DONE cycle.
// ---------------------------------------------------------------------------
module alu_muldiv_seq
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER,
    parameter int CNTW  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_port_A,
    output logic [WIDTH-1:0] alu_port_B,
    output aluop_t           alu_aluop,
    input  logic [WIDTH-1:0] alu_output_port,
    input  logic             alu_overflow
);

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    muldiv_state_t    state_reg,   state_next;
    logic [CNTW-1:0]  counter_reg, counter_next;
    logic [WIDTH-1:0] hi_reg,      hi_next;
    logic [WIDTH-1:0] lo_reg,      lo_next;
    logic [WIDTH-1:0] opa_reg,     opa_next;
    logic [WIDTH-1:0] opb_reg,     opb_next;
    logic             ge_reg,      ge_next;

    // Partial remainder shifted left with the next dividend bit. It always
    // fits in WIDTH bits: the remainder never exceeds the dividend prefix,
    // which is below 2^(WIDTH-1) before the final shift.
    logic [WIDTH-1:0] r_sh;
    assign r_sh = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        opa_next     = opa_reg;
        opb_next     = opb_reg;
        ge_next      = ge_reg;
        alu_port_A   = '0;
        alu_port_B   = '0;
        alu_aluop    = ALU_ADD;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    opa_next     = opa;
                    opb_next     = opb;
                    counter_next = '0;
                    hi_next      = '0;
                    if (op == MD_MULTU) begin
                        lo_next    = opb;
                        state_next = MUL;
                    end else begin
                        lo_next    = opa;
                        state_next = DIV_CMP;
                    end
                end
            end

            MUL: begin
                // Shift-add: the multiplier sits in lo and is consumed LSB
                // first while product bits shift in from hi.
                alu_port_A = hi_reg;
                alu_port_B = opa_reg;
                alu_aluop  = ALU_ADD;
                if (lo_reg[0]) begin
                    {hi_next, lo_next} = {alu_overflow, alu_output_port, lo_reg[WIDTH-1:1]};
                end else begin
                    {hi_next, lo_next} = {1'b0, hi_reg, lo_reg[WIDTH-1:1]};
                end
                counter_next = counter_reg + 1'b1;
                if (counter_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end

            DIV_CMP: begin
                // Restoring division: lo shifts out dividend bits at the top
                // and collects quotient bits at the bottom.
                alu_port_A = r_sh;
                alu_port_B = opb_reg;
                alu_aluop  = ALU_SLTU;
                hi_next    = r_sh;
                lo_next    = {lo_reg[WIDTH-2:0], 1'b0};
                ge_next    = ~alu_output_port[0];
                state_next = DIV_SUB;
            end

            DIV_SUB: begin
                alu_port_A = hi_reg;
                alu_port_B = opb_reg;
                alu_aluop  = ALU_SUB;
                if (ge_reg) begin
                    hi_next    = alu_output_port;
                    lo_next[0] = 1'b1;
                end
                counter_next = counter_reg + 1'b1;
                if (counter_reg == LAST_ITER) begin
                    state_next = DONE;
                end else begin
                    state_next = DIV_CMP;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            ge_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            opa_reg     <= opa_next;
            opb_reg     <= opb_next;
            ge_reg      <= ge_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Scoreboard bench for alu_muldiv_seq wired to a cpu_alu instance. The
// driver pushes the expected {hi,lo} and completion cycle for each accepted
// request; the monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;
    import cpu_types_pkg::*;

    localparam int W = 32;
    localparam int MUL_LAT = 32;   // edges from the accepting edge to done
    localparam int DIV_LAT = 64;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    muldiv_op_t   op = MD_MULTU;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [W-1:0] alu_port_A, alu_port_B, alu_output_port;
    aluop_t       alu_aluop;
    logic         alu_overflow;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   check_idle_next = 0;
    exp_t exp_q[$];

    alu_muldiv_seq #(.WIDTH(W), .CNTW(5)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_port_A(alu_port_A), .alu_port_B(alu_port_B), .alu_aluop(alu_aluop),
        .alu_output_port(alu_output_port), .alu_overflow(alu_overflow)
    );

    cpu_alu #(.WIDTH(W)) alu_i (
        .alu_port_A(alu_port_A), .alu_port_B(alu_port_B), .alu_aluop(alu_aluop),
        .alu_output_port(alu_output_port), .alu_overflow(alu_overflow)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
        end
    endtask

    // Reference model: plain 64-bit product, or quotient/remainder with the
    // divide-by-zero convention lo=all ones, hi=dividend.
    function automatic logic [63:0] model(input muldiv_op_t o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [63:0] r;
        if (o == MD_MULTU) r = {32'd0, a} * {32'd0, b};
        else if (b == 0)   r = {a, 32'hFFFF_FFFF};
        else               r = {a % b, a / b};
        return r;
    endfunction

    // Monitor: compare on every done pulse; the cycle after must be idle.
    always @(negedge CLK) begin
        exp_t e;
        if (check_idle_next) begin
            check_idle_next = 0;
            chk("idle_after_done_busy", 64'(busy), 64'd0);
            chk("idle_after_done_done", 64'(done), 64'd0);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("op %s hi=0x%08h lo=0x%08h cyc=%0d", e.name, hi, lo, cyc);
                chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                check_idle_next = 1;
            end
        end
    end

    task automatic issue_op(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input string name);
        exp_t        e;
        logic [63:0] r;
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        r = model(o, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cyc = cyc + ((o == MD_MULTU) ? MUL_LAT : DIV_LAT);
        e.name = name;
        exp_q.push_back(e);
        // Scramble inputs while busy; they must have no effect.
        opa = $urandom; opb = $urandom; op = muldiv_op_t'($urandom_range(0, 1));
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_waiting_done", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        issue_op(o, a, b, name);
        wait_empty();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(1, 20));
            3:       return 32'h8000_0000 | $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        // Reset state
        RST = 1'b1; start = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0; start = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // Directed cases
        run_op(MD_MULTU, 32'd3, 32'd5, "mul_3x5");
        repeat (3) @(posedge CLK);
        #1;
        chk("hold_hi_idle", 64'(hi), 64'd0);
        chk("hold_lo_idle", 64'(lo), 64'd15);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
        run_op(MD_DIVU, 32'd100, 32'd7, "div_100_7");
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "div_big");
        run_op(MD_DIVU, 32'h1234_5678, 32'd0, "div_by_zero");

        // Start pulses mid-operation and during DONE are ignored
        issue_op(MD_MULTU, 32'd6, 32'd7, "mul_6x7_ignored_starts");
        repeat (4) @(posedge CLK);
        #1;
        op = MD_DIVU; opa = 32'd99; opb = 32'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("reached_done_for_ignore_test", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_empty();
        repeat (40) @(posedge CLK);
        #1;

        // Reset aborts a DIVU in flight
        issue_op(MD_DIVU, 32'hDEAD_BEEF, 32'd13, "div_aborted");
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        check_idle_next = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        run_op(MD_MULTU, 32'd2, 32'd3, "mul_after_abort");

        // Randomised operations against the reference model
        for (int i = 0; i < 24; i++) begin
            muldiv_op_t o;
            logic [W-1:0] a, b;
            o = muldiv_op_t'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op(o, a, b, (o == MD_MULTU) ? "rand_mul" : "rand_div");
        end

        // Quiet period: any stray done pulse is flagged by the monitor
        repeat (80) @(posedge CLK);
        #1;
        chk("final_busy", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
